quad_pos_tracker: RTL and testbench



---
 rtl/quad_pos_pkg.sv | 31 +++
 rtl/quad_pos_tracker_if.sv | 23 ++
 rtl/quad_axis.sv | 81 ++++++++
 rtl/quad_pos_tracker.sv | 91 +++++++++
 tb/tb_quad_pos_tracker.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/quad_pos_pkg.sv
// Shared definitions for the quadrature position tracker: status bit map,
// decode result encoding and the default counter start value.
package quad_pos_pkg;

  localparam int ST_BTN    = 0;
  localparam int ST_X_DIR  = 1;
  localparam int ST_Y_DIR  = 2;
  localparam int ST_X_OVF  = 3;
  localparam int ST_Y_OVF  = 4;
  localparam int ST_X_ERR  = 5;
  localparam int ST_Y_ERR  = 6;
  localparam int ST_FROZEN = 7;

  localparam logic [7:0] INIT_DEFAULT = 8'd128;

  typedef enum logic [1:0] {
    DEC_NONE,
    DEC_INC,
    DEC_DEC,
    DEC_ILLEGAL
  } dec_e;

  // Forward order is 00 -> 01 -> 11 -> 10 -> 00, so the successor of {a,b} is {b,~a}.
  function automatic dec_e quad_decode(input logic [1:0] prev, input logic [1:0] cur);
    if (cur == prev)            return DEC_NONE;
    if ((cur ^ prev) == 2'b11)  return DEC_ILLEGAL;
    if (cur == {prev[0], ~prev[1]}) return DEC_INC;
    return DEC_DEC;
  endfunction

endpackage

// File: rtl/quad_pos_tracker_if.sv
// Encoder/button inputs, control strobes and snapshot outputs of the tracker.
interface quad_pos_tracker_if;
  logic       xa;
  logic       xb;
  logic       ya;
  logic       yb;
  logic       btn_in;
  logic       freeze;
  logic       clear;
  logic [7:0] x_pos;
  logic [7:0] y_pos;
  logic [7:0] status;

  modport master (
    output xa, xb, ya, yb, btn_in, freeze, clear,
    input  x_pos, y_pos, status
  );

  modport slave (
    input  xa, xb, ya, yb, btn_in, freeze, clear,
    output x_pos, y_pos, status
  );
endinterface

// File: rtl/quad_axis.sv
// One encoder axis: 2-flop synchroniser, 4x quadrature decode, 8-bit counter
// with saturate/wrap, and direction / sticky overflow / sticky error flags.
module quad_axis
  import quad_pos_pkg::*;
#(
  parameter int         SATURATE = 1,
  parameter logic [7:0] INIT     = INIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_a,
  input  logic       i_b,
  input  logic       i_clear,
  output logic [7:0] o_count,
  output logic       o_dir,
  output logic       o_ovf,
  output logic       o_err
);

  logic [1:0] r_sync1, r_sync2, r_prev;
  logic [7:0] r_count;
  logic       r_dir, r_ovf, r_err;
  dec_e       w_dec;

  assign w_dec = quad_decode(r_prev, r_sync2);

  // NOTE: all state uses <= so every flop samples pre-edge values; this is what
  // makes the sync1 -> sync2 -> prev chain a real pipeline rather than a wire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 2'b00;
      r_sync2 <= 2'b00;
      r_prev  <= 2'b00;
      r_count <= INIT;
      r_dir   <= 1'b0;
      r_ovf   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_sync1 <= {i_a, i_b};
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;

      // Direction follows legal steps even on a clear cycle.
      if (w_dec == DEC_INC)      r_dir <= 1'b1;
      else if (w_dec == DEC_DEC) r_dir <= 1'b0;

      if (i_clear) begin
        r_count <= INIT;
        r_ovf   <= 1'b0;
        r_err   <= 1'b0;
      end else begin
        case (w_dec)
          DEC_INC: begin
            if (r_count == 8'hFF) begin
              r_ovf <= 1'b1;
              if (SATURATE == 0) r_count <= 8'h00;
            end else begin
              r_count <= r_count + 8'd1;
            end
          end
          DEC_DEC: begin
            if (r_count == 8'h00) begin
              r_ovf <= 1'b1;
              if (SATURATE == 0) r_count <= 8'hFF;
            end else begin
              r_count <= r_count - 8'd1;
            end
          end
          DEC_ILLEGAL: r_err <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign o_count = r_count;
  assign o_dir   = r_dir;
  assign o_ovf   = r_ovf;
  assign o_err   = r_err;

endmodule

// File: rtl/quad_pos_tracker.sv
// Two-axis encoder tracker with debounced button and a freezable output
// snapshot so one I2C read sees x_pos, y_pos and status from the same cycle.
module quad_pos_tracker
  import quad_pos_pkg::*;
#(
  parameter int         SATURATE        = 1,
  parameter int         DEBOUNCE_CYCLES = 16,
  parameter logic [7:0] X_INIT          = INIT_DEFAULT,
  parameter logic [7:0] Y_INIT          = INIT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  quad_pos_tracker_if.slave bus
);

  localparam logic [15:0] DEB_LAST = 16'(DEBOUNCE_CYCLES - 1);

  logic [7:0]  w_x_count, w_y_count;
  logic        w_x_dir, w_x_ovf, w_x_err;
  logic        w_y_dir, w_y_ovf, w_y_err;
  logic        r_btn_sync1, r_btn_sync2, r_btn;
  logic [15:0] r_deb_cnt;
  logic [7:0]  w_live_status;
  logic [7:0]  r_x_pos, r_y_pos, r_status;

  quad_axis #(.SATURATE(SATURATE), .INIT(X_INIT)) u_x (
    .clk(clk), .rst_n(rst_n), .i_a(bus.xa), .i_b(bus.xb), .i_clear(bus.clear),
    .o_count(w_x_count), .o_dir(w_x_dir), .o_ovf(w_x_ovf), .o_err(w_x_err)
  );

  quad_axis #(.SATURATE(SATURATE), .INIT(Y_INIT)) u_y (
    .clk(clk), .rst_n(rst_n), .i_a(bus.ya), .i_b(bus.yb), .i_clear(bus.clear),
    .o_count(w_y_count), .o_dir(w_y_dir), .o_ovf(w_y_ovf), .o_err(w_y_err)
  );

  // Button is accepted only after it has disagreed for DEBOUNCE_CYCLES cycles in a row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btn_sync1 <= 1'b0;
      r_btn_sync2 <= 1'b0;
      r_btn       <= 1'b0;
      r_deb_cnt   <= '0;
    end else begin
      r_btn_sync1 <= bus.btn_in;
      r_btn_sync2 <= r_btn_sync1;
      if (r_btn_sync2 != r_btn) begin
        if (r_deb_cnt == DEB_LAST) begin
          r_btn     <= r_btn_sync2;
          r_deb_cnt <= '0;
        end else begin
          r_deb_cnt <= r_deb_cnt + 16'd1;
        end
      end else begin
        r_deb_cnt <= '0;
      end
    end
  end

  always_comb begin
    // NOTE: default first so every bit is driven on every path and no latch is inferred.
    w_live_status           = '0;
    w_live_status[ST_BTN]   = r_btn;
    w_live_status[ST_X_DIR] = w_x_dir;
    w_live_status[ST_Y_DIR] = w_y_dir;
    w_live_status[ST_X_OVF] = w_x_ovf;
    w_live_status[ST_Y_OVF] = w_y_ovf;
    w_live_status[ST_X_ERR] = w_x_err;
    w_live_status[ST_Y_ERR] = w_y_err;
  end

  // The frozen bit is overridden after the snapshot load so it always tracks freeze.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x_pos  <= X_INIT;
      r_y_pos  <= Y_INIT;
      r_status <= 8'h00;
    end else begin
      if (!bus.freeze) begin
        r_x_pos  <= w_x_count;
        r_y_pos  <= w_y_count;
        r_status <= w_live_status;
      end
      r_status[ST_FROZEN] <= bus.freeze;
    end
  end

  assign bus.x_pos  = r_x_pos;
  assign bus.y_pos  = r_y_pos;
  assign bus.status = r_status;

endmodule

// File: tb/tb_quad_pos_tracker.sv
// Scoreboard bench: a saturating and a wrapping tracker share one stimulus
// stream; a cycle-level reference model predicts both and a monitor compares.
module tb_quad_pos_tracker;

  localparam int INIT_V = 128;
  localparam int DEB    = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tb_xa = 0, tb_xb = 0, tb_ya = 0, tb_yb = 0, tb_btn = 0, tb_freeze = 0, tb_clear = 0;

  int n_checks = 0;
  int n_errors = 0;

  quad_pos_tracker_if if_sat ();
  quad_pos_tracker_if if_wrap ();

  assign if_sat.xa = tb_xa;       assign if_wrap.xa = tb_xa;
  assign if_sat.xb = tb_xb;       assign if_wrap.xb = tb_xb;
  assign if_sat.ya = tb_ya;       assign if_wrap.ya = tb_ya;
  assign if_sat.yb = tb_yb;       assign if_wrap.yb = tb_yb;
  assign if_sat.btn_in = tb_btn;  assign if_wrap.btn_in = tb_btn;
  assign if_sat.freeze = tb_freeze; assign if_wrap.freeze = tb_freeze;
  assign if_sat.clear = tb_clear; assign if_wrap.clear = tb_clear;

  quad_pos_tracker #(.SATURATE(1), .DEBOUNCE_CYCLES(DEB), .X_INIT(8'd128), .Y_INIT(8'd128))
    u_sat (.clk(clk), .rst_n(rst_n), .bus(if_sat));
  quad_pos_tracker #(.SATURATE(0), .DEBOUNCE_CYCLES(DEB), .X_INIT(8'd128), .Y_INIT(8'd128))
    u_wrap (.clk(clk), .rst_n(rst_n), .bus(if_wrap));

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int x_s; int y_s; int st_s;
    int x_w; int y_w; int st_w;
  } exp_t;

  exp_t exp_q[$];
  logic [1:0] hx[$], hy[$];
  logic       hb[$];
  int m_cnt[2][2];
  bit m_dir[2][2], m_ovf[2][2], m_err[2][2];
  bit m_deb, m_frozen;
  int m_run;
  int m_ox[2], m_oy[2], m_ost[2];

  function automatic int gidx(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] gray(input int idx);
    case (idx)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  function automatic int live_status(input int i);
    return int'(m_deb) | (int'(m_dir[i][0]) << 1) | (int'(m_dir[i][1]) << 2) |
           (int'(m_ovf[i][0]) << 3) | (int'(m_ovf[i][1]) << 4) |
           (int'(m_err[i][0]) << 5) | (int'(m_err[i][1]) << 6);
  endfunction

  task automatic model_reset();
    hx.delete(); hy.delete(); hb.delete();
    repeat (3) begin hx.push_back(2'b00); hy.push_back(2'b00); hb.push_back(1'b0); end
    for (int i = 0; i < 2; i++) begin
      for (int a = 0; a < 2; a++) begin
        m_cnt[i][a] = INIT_V; m_dir[i][a] = 0; m_ovf[i][a] = 0; m_err[i][a] = 0;
      end
      m_ox[i] = INIT_V; m_oy[i] = INIT_V; m_ost[i] = 0;
    end
    m_deb = 0; m_run = 0; m_frozen = 0;
  endtask

  task automatic model_axis(input int i, input int a, input logic [1:0] prev, input logic [1:0] cur);
    int d, nv;
    d = (gidx(cur) - gidx(prev) + 4) % 4;
    if (d == 1) m_dir[i][a] = 1;
    if (d == 3) m_dir[i][a] = 0;
    if (tb_clear) begin
      m_cnt[i][a] = INIT_V; m_ovf[i][a] = 0; m_err[i][a] = 0;
    end else if (d == 2) begin
      m_err[i][a] = 1;
    end else if (d != 0) begin
      nv = m_cnt[i][a] + ((d == 1) ? 1 : -1);
      if (nv < 0 || nv > 255) begin
        m_ovf[i][a] = 1;
        nv = (i == 0) ? ((nv < 0) ? 0 : 255) : ((nv + 256) % 256);
      end
      m_cnt[i][a] = nv;
    end
  endtask

  initial begin
    exp_t e;
    model_reset();
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        model_reset();
      end else begin
        if (!tb_freeze)
          for (int i = 0; i < 2; i++) begin
            m_ox[i] = m_cnt[i][0]; m_oy[i] = m_cnt[i][1]; m_ost[i] = live_status(i);
          end
        m_frozen = tb_freeze;
        hx.push_back({tb_xa, tb_xb}); hy.push_back({tb_ya, tb_yb}); hb.push_back(tb_btn);
        if (hx.size() > 4) begin void'(hx.pop_front()); void'(hy.pop_front()); void'(hb.pop_front()); end
        // Decode sees the pins sampled two and three edges ago (synchroniser depth).
        for (int i = 0; i < 2; i++) begin
          model_axis(i, 0, hx[$-3], hx[$-2]);
          model_axis(i, 1, hy[$-3], hy[$-2]);
        end
        if (hb[$-2] != m_deb) begin
          m_run++;
          if (m_run == DEB) begin m_deb = hb[$-2]; m_run = 0; end
        end else begin
          m_run = 0;
        end
      end
      e.x_s = m_ox[0]; e.y_s = m_oy[0]; e.st_s = m_ost[0] | (int'(m_frozen) << 7);
      e.x_w = m_ox[1]; e.y_w = m_oy[1]; e.st_w = m_ost[1] | (int'(m_frozen) << 7);
      exp_q.push_back(e);
    end
  end

  // Monitor: outputs are registered, so every cycle presents a new snapshot.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_sat_x",   int'(if_sat.x_pos),   e.x_s);
        check("sb_sat_y",   int'(if_sat.y_pos),   e.y_s);
        check("sb_sat_st",  int'(if_sat.status),  e.st_s);
        check("sb_wrap_x",  int'(if_wrap.x_pos),  e.x_w);
        check("sb_wrap_y",  int'(if_wrap.y_pos),  e.y_w);
        check("sb_wrap_st", int'(if_wrap.status), e.st_w);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  int x_idx = 0, y_idx = 0;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic x_step(input int d, input int hold);
    x_idx = (x_idx + d + 4) % 4;
    {tb_xa, tb_xb} = gray(x_idx);
    tick(hold);
  endtask

  task automatic y_step(input int d, input int hold);
    y_idx = (y_idx + d + 4) % 4;
    {tb_ya, tb_yb} = gray(y_idx);
    tick(hold);
  endtask

  task automatic pulse_clear();
    tb_clear = 1; tick(1); tb_clear = 0;
  endtask

  task automatic check_both(input string tag, input int xs, input int ys, input int sts,
                            input int xw, input int yw, input int stw);
    check({tag, "_sat_x"},  int'(if_sat.x_pos),  xs);
    check({tag, "_sat_y"},  int'(if_sat.y_pos),  ys);
    check({tag, "_sat_st"}, int'(if_sat.status), sts);
    check({tag, "_wrap_x"}, int'(if_wrap.x_pos), xw);
    check({tag, "_wrap_y"}, int'(if_wrap.y_pos), yw);
    check({tag, "_wrap_st"}, int'(if_wrap.status), stw);
  endtask

  initial begin
    tick(3);
    rst_n = 1;
    tick(10);
    check_both("reset_idle", 128, 128, 8'h00, 128, 128, 8'h00);

    // First forward step: visible exactly three edges after it is sampled.
    x_step(1, 3);
    check("latency_early", int'(if_sat.x_pos), 128);
    tick(1);
    check("latency_exact", int'(if_sat.x_pos), 129);
    for (int i = 0; i < 4; i++) x_step(1, 4);
    tick(4);
    check_both("fwd5", 133, 128, 8'h02, 133, 128, 8'h02);

    // Count down to 2, then four more: saturate at 0 versus wrap to 254.
    for (int i = 0; i < 131; i++) x_step(-1, 4);
    tick(4);
    check_both("down_to_2", 2, 128, 8'h00, 2, 128, 8'h00);
    for (int i = 0; i < 4; i++) x_step(-1, 4);
    tick(4);
    check_both("underflow", 0, 128, 8'h08, 254, 128, 8'h08);
    pulse_clear();
    tick(3);
    check_both("clear_x", 128, 128, 8'h00, 128, 128, 8'h00);

    // Illegal Y jump 00 -> 11, then clear.
    y_step(2, 6);
    check_both("y_illegal", 128, 128, 8'h40, 128, 128, 8'h40);
    pulse_clear();
    tick(3);
    check_both("y_clear", 128, 128, 8'h00, 128, 128, 8'h00);

    // Freeze across three forward steps.
    tb_freeze = 1;
    tick(2);
    for (int i = 0; i < 3; i++) x_step(1, 4);
    tick(3);
    check_both("frozen", 128, 128, 8'h80, 128, 128, 8'h80);
    tb_freeze = 0;
    tick(1);
    check_both("unfrozen", 131, 128, 8'h02, 131, 128, 8'h02);

    // Button: one cycle short of the debounce window, then exactly the window.
    tb_btn = 1; tick(DEB - 1); tb_btn = 0;
    tick(25);
    check("btn_glitch", int'(if_sat.status), 8'h02);
    tb_btn = 1; tick(DEB); tb_btn = 0;
    tick(4);
    check("btn_accept", int'(if_sat.status), 8'h03);
    tick(20);
    check("btn_release", int'(if_sat.status), 8'h02);

    // Clear lands on the same edge as a count update: clear wins.
    x_step(1, 2);
    pulse_clear();
    tick(3);
    check_both("clear_vs_count", 128, 128, 8'h02, 128, 128, 8'h02);

    // Count up past 255: saturate at 255 versus wrap to 2.
    for (int i = 0; i < 130; i++) x_step(1, 4);
    tick(4);
    check_both("overflow", 255, 128, 8'h0A, 2, 128, 8'h0A);

    // Asynchronous reset between clock edges.
    #2;
    rst_n = 0;
    tb_xa = 0; tb_xb = 0; tb_ya = 0; tb_yb = 0; x_idx = 0; y_idx = 0;
    #1;
    check_both("async_reset", 128, 128, 8'h00, 128, 128, 8'h00);
    tick(3);
    rst_n = 1;
    tick(5);
    check_both("after_reset", 128, 128, 8'h00, 128, 128, 8'h00);

    // Random traffic, checked cycle by cycle by the scoreboard.
    for (int it = 0; it < 400; it++) begin
      int act;
      act = int'($urandom_range(0, 9));
      if (act <= 3)      x_step(($urandom_range(0, 15) == 0) ? 2 : (($urandom_range(0, 2) == 0) ? -1 : 1), 0);
      else if (act <= 6) y_step(($urandom_range(0, 15) == 0) ? 2 : (($urandom_range(0, 1) == 0) ? -1 : 1), 0);
      else if (act == 7) tb_btn = ~tb_btn;
      else if (act == 8) tb_freeze = ~tb_freeze;
      else               pulse_clear();
      tick(int'($urandom_range(1, (act == 7) ? 24 : 8)));
    end
    tb_freeze = 0;
    tick(10);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
